// File: rtl/regfile_670_arb.sv
// regfile_670_arb: round-robin write arbiter, strobe timer and read sequencer for ganged 74x670 parts.
// Define REGFILE_670_ARB_BYPASS_EN to forward in-flight write data to a same-address read instead of stalling it.
module regfile_670_arb #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned WE_CYCLES = 2,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req0,
  input  logic [1:0]       wa0,
  input  logic [WIDTH-1:0] d0,
  output logic             ack0,
  input  logic             req1,
  input  logic [1:0]       wa1,
  input  logic [WIDTH-1:0] d1,
  output logic             ack1,
  input  logic             rreq,
  input  logic [1:0]       rra,
  output logic             rbusy,
  output logic             rvalid,
  output logic [WIDTH-1:0] rq,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       wa,
  output logic             nwe,
  output logic [1:0]       ra,
  output logic             nre,
  input  logic [WIDTH-1:0] q
);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_SETUP  = 2'd1;
  localparam logic [1:0] W_STROBE = 2'd2;
  localparam logic [1:0] W_HOLD   = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_READ = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  localparam logic [3:0] WE_M1 = 4'(WE_CYCLES - 1);
  localparam logic [3:0] RD_M1 = 4'(RD_LAT - 1);

  // Write side
  logic [1:0]       w_state_q, w_state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             gnt_q, gnt_d;
  logic             ptr_q, ptr_d;
  logic             pick1;
  logic [1:0]       wa_q, wa_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             nwe_q, ack0_q, ack1_q;

  // Read side
  logic [1:0]       r_state_q, r_state_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic [1:0]       ra_q, ra_d;
  logic [WIDTH-1:0] rq_q, rq_d;
  logic             nre_q, rvalid_q, rbusy_q;

  logic             w_busy_q, w_busy_d;
  logic             haz_new, haz_cur;

  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    wa_d      = wa_q;
    d_d       = d_q;
    pick1     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (req0 || req1) begin
          // ptr_q=1 favours requester 1 when both are asking
          pick1     = req1 && (!req0 || ptr_q);
          gnt_d     = pick1;
          ptr_d     = !pick1;
          wa_d      = pick1 ? wa1 : wa0;
          d_d       = pick1 ? d1 : d0;
          w_state_d = W_SETUP;
        end
      end
      W_SETUP: begin
        wcnt_d    = WE_M1;
        w_state_d = W_STROBE;
      end
      W_STROBE: begin
        if (wcnt_q == '0) begin
          w_state_d = W_HOLD;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      W_HOLD:  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign w_busy_q = (w_state_q != W_IDLE);
  assign w_busy_d = (w_state_d != W_IDLE);

  // A write granted on this same edge also counts, so a read never overlaps a strobe to its word
  assign haz_new = (w_busy_q && (wa_q == rra))  || (w_busy_d && (wa_d == rra));
  assign haz_cur = (w_busy_q && (wa_q == ra_q)) || (w_busy_d && (wa_d == ra_q));

  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    ra_d      = ra_q;
    rq_d      = rq_q;
    case (r_state_q)
      R_IDLE: begin
        if (rreq) begin
          ra_d = rra;
          if (haz_new) begin
`ifdef REGFILE_670_ARB_BYPASS_EN
            rq_d      = d_d;
            r_state_d = R_DONE;
`else
            r_state_d = R_WAIT;
`endif
          end else begin
            rcnt_d    = RD_M1;
            r_state_d = R_READ;
          end
        end
      end
      R_WAIT: begin
        if (!haz_cur) begin
          rcnt_d    = RD_M1;
          r_state_d = R_READ;
        end
      end
      R_READ: begin
        if (rcnt_q == '0) begin
          rq_d      = q;
          r_state_d = R_DONE;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      R_DONE:  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Strobes and pulses are registered from next-state so the '670 pins never see decode glitches
  always_ff @(posedge clk) begin
    if (!nreset) begin
      w_state_q <= W_IDLE;
      wcnt_q    <= '0;
      gnt_q     <= 1'b0;
      ptr_q     <= 1'b0;
      wa_q      <= '0;
      d_q       <= '0;
      nwe_q     <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wcnt_q    <= wcnt_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      wa_q      <= wa_d;
      d_q       <= d_d;
      nwe_q     <= (w_state_d != W_STROBE);
      ack0_q    <= (w_state_d == W_HOLD) && !gnt_d;
      ack1_q    <= (w_state_d == W_HOLD) && gnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state_q <= R_IDLE;
      rcnt_q    <= '0;
      ra_q      <= '0;
      rq_q      <= '0;
      nre_q     <= 1'b1;
      rvalid_q  <= 1'b0;
      rbusy_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
      ra_q      <= ra_d;
      rq_q      <= rq_d;
      nre_q     <= (r_state_d != R_READ);
      rvalid_q  <= (r_state_d == R_DONE);
      rbusy_q   <= (r_state_d != R_IDLE);
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign nwe    = nwe_q;
  assign wa     = wa_q;
  assign d      = d_q;
  assign ra     = ra_q;
  assign nre    = nre_q;
  assign rq     = rq_q;
  assign rvalid = rvalid_q;
  assign rbusy  = rbusy_q;

endmodule
